// File: rtl/data_switch_pkg.sv
// Shared definitions for the stream merge/split blocks: FSM encodings,
// beat-counter width, default data width and the group-length helper.
package data_switch_pkg;

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned DEF_DW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL1 = 2'd1,
    SEL2 = 2'd2
  } merge_state_e;

  // Beats per group; 16x8 bits always fits the 24-bit counter domain.
  function automatic logic [CNT_W-1:0] group_len(input logic [15:0] packet_size,
                                                 input logic [7:0]  pp_group);
    return CNT_W'(packet_size) * CNT_W'(pp_group);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer with one sideband bit carried alongside
// the data; ready depends only on fill level, never on the downstream ready.
module axis_skid_buf
  import data_switch_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] in_tdata,
  input  logic          in_tuser,
  input  logic          in_tvalid,
  output logic          in_tready,
  output logic [DW-1:0] out_tdata,
  output logic          out_tuser,
  output logic          out_tvalid,
  input  logic          out_tready
);

  logic [DW:0] ent0;
  logic [DW:0] ent1;
  logic [DW:0] din;
  logic [1:0]  fill;
  logic        push;
  logic        pop;

  assign din        = {in_tuser, in_tdata};
  assign in_tready  = (fill != 2'd2);
  assign out_tvalid = (fill != 2'd0);
  assign out_tdata  = ent0[DW-1:0];
  assign out_tuser  = ent0[DW];
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;

  // ent0 is always the head; simultaneous push/pop only happens at fill==1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fill <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fill == 2'd0) ent0 <= din;
          else              ent1 <= din;
          fill <= fill + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          fill <= fill - 2'd1;
        end
        2'b11: ent0 <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_merge.sv
// Merges two AXI streams into one by alternating groups of
// PP_GROUP*PACKET_SIZE beats (in1 first). DATA_MERGE_TLAST_EN adds axis_out_tlast.
module data_merge
  import data_switch_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [15:0]   PACKET_SIZE,
  input  logic [7:0]    PP_GROUP,
  input  logic [DW-1:0] axis_in1_tdata,
  input  logic          axis_in1_tvalid,
  output logic          axis_in1_tready,
  input  logic [DW-1:0] axis_in2_tdata,
  input  logic          axis_in2_tvalid,
  output logic          axis_in2_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
`ifdef DATA_MERGE_TLAST_EN
  output logic          axis_out_tlast,
`endif
  input  logic          axis_out_tready,
  output logic          cfg_zero
);

  merge_state_e     state;
  merge_state_e     state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] glen;
  logic [CNT_W-1:0] glen_d;
  logic [CNT_W-1:0] new_glen;
  logic             cfg_zero_d;
  logic             skid_ready;
  logic             beat_valid;
  logic [DW-1:0]    beat_data;
  logic             beat_acc;
  logic             last_beat;

  assign new_glen        = group_len(PACKET_SIZE, PP_GROUP);
  assign axis_in1_tready = (state == SEL1) && skid_ready;
  assign axis_in2_tready = (state == SEL2) && skid_ready;
  assign beat_acc        = beat_valid && skid_ready;
  assign last_beat       = (cnt == glen - CNT_W'(1));

  // Steer the selected input towards the skid buffer.
  always_comb begin
    beat_valid = 1'b0;
    beat_data  = '0;
    case (state)
      SEL1: begin
        beat_valid = axis_in1_tvalid;
        beat_data  = axis_in1_tdata;
      end
      SEL2: begin
        beat_valid = axis_in2_tvalid;
        beat_data  = axis_in2_tdata;
      end
      default: ;
    endcase
  end

  // Group sequencing; group length is only sampled in IDLE or at a boundary.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    glen_d  = glen;
    case (state)
      IDLE: begin
        glen_d = new_glen;
        if (new_glen != '0) state_d = SEL1;
      end
      SEL1, SEL2: begin
        if (beat_acc) begin
          if (last_beat) begin
            cnt_d  = '0;
            glen_d = new_glen;
            if (new_glen == '0)     state_d = IDLE;
            else if (state == SEL1) state_d = SEL2;
            else                    state_d = SEL1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cfg_zero_d = (glen_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      glen     <= '0;
      cfg_zero <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      glen     <= glen_d;
      cfg_zero <= cfg_zero_d;
    end
  end

`ifdef DATA_MERGE_TLAST_EN
  logic tlast_in;
  assign tlast_in = last_beat;
`else
  logic tlast_in;
  logic tlast_unused;
  assign tlast_in = 1'b0;
`endif

  axis_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk        (clk),
    .resetn     (resetn),
    .in_tdata   (beat_data),
    .in_tuser   (tlast_in),
    .in_tvalid  (beat_valid),
    .in_tready  (skid_ready),
    .out_tdata  (axis_out_tdata),
`ifdef DATA_MERGE_TLAST_EN
    .out_tuser  (axis_out_tlast),
`else
    .out_tuser  (tlast_unused),
`endif
    .out_tvalid (axis_out_tvalid),
    .out_tready (axis_out_tready)
  );

endmodule
